// File: rtl/oam_dma_controller.sv
// Sprite DMA: a CPU write to TRIGGER_ADDR halts the CPU and copies page {data,00} to the OAM data port.
// One read/write pair per byte; all state advances on ce only, outputs decode from registered state.
module oam_dma_controller #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        odd_cycle,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_write,
  input  logic [7:0]  mem_din,
  output logic        pause_cpu,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_read,
  output logic        dma_write,
  output logic [7:0]  dma_dout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] count_q, count_d;
  logic [7:0] buf_q, buf_d;
  logic       trigger;

  assign trigger  = cpu_write && (cpu_addr == TRIGGER_ADDR);
  assign dma_dout = buf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      page_q  <= 8'h00;
      count_q <= 8'h00;
      buf_q   <= 8'h00;
    end else if (ce) begin
      state_q <= state_d;
      page_q  <= page_d;
      count_q <= count_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    count_d    = count_q;
    buf_d      = buf_q;
    pause_cpu  = 1'b1;
    dma_active = 1'b1;
    dma_addr   = 16'h0000;
    dma_read   = 1'b0;
    dma_write  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pause_cpu  = 1'b0;
        dma_active = 1'b0;
        if (trigger) begin
          page_d  = cpu_din;
          count_d = 8'h00;
          state_d = ST_HALT;
        end
      end
      // An odd first cycle needs one extra idle cycle so reads land on get phases.
      ST_HALT:  state_d = odd_cycle ? ST_ALIGN : ST_READ;
      ST_ALIGN: state_d = ST_READ;
      ST_READ: begin
        dma_addr = {page_q, count_q};
        dma_read = 1'b1;
        buf_d    = mem_din;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        dma_addr  = DEST_ADDR;
        dma_write = 1'b1;
        count_d   = count_q + 8'd1;
        state_d   = (count_q == 8'hFF) ? ST_IDLE : ST_READ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: random transfers checked against an arithmetic model of the bus-op sequence.
`timescale 1ns/1ps
module tb_oam_dma_controller;
  logic        clk = 1'b0;
  logic        reset, ce, odd_cycle, cpu_write;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din, mem_din;
  logic        pause_cpu, dma_active, dma_read, dma_write;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic [7:0]  mem_key;
  logic [7:0]  last_byte;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign mem_din = dma_addr[7:0] ^ mem_key;

  oam_dma_controller dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .odd_cycle (odd_cycle),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_write (cpu_write),
    .mem_din   (mem_din),
    .pause_cpu (pause_cpu),
    .dma_active(dma_active),
    .dma_addr  (dma_addr),
    .dma_read  (dma_read),
    .dma_write (dma_write),
    .dma_dout  (dma_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One ce cycle as seen on the bus; write data only matters on write cycles.
  function automatic logic [27:0] op_word(input logic p, input logic a, input logic r,
                                          input logic w, input logic [15:0] ad, input logic [7:0] d);
    return {p, a, r, w, ad, (w ? d : 8'h00)};
  endfunction

  task automatic idle_pokes(input int n);
    for (int i = 0; i < n; i++) begin
      ce = 1'b1;
      if (i % 2 == 0) begin
        cpu_write = 1'b1;
        cpu_addr  = 16'($urandom);
        if (cpu_addr == 16'h4014) cpu_addr = 16'h4015;
      end else begin
        cpu_write = 1'b0;
        cpu_addr  = 16'h4014;
      end
      cpu_din = 8'($urandom);
      @(posedge clk); #1;
      chk("no_start", 32'({pause_cpu, dma_active, dma_read, dma_write}), 32'h0);
      chk("idle_addr", 32'(dma_addr), 32'h0);
      chk("idle_dout", 32'(dma_dout), 32'(last_byte));
    end
    cpu_write = 1'b0;
  endtask

  task automatic run_transfer(input logic [7:0] page, input logic odd, input int ce_mode,
                              input logic poke, input int abort_at, input logic [7:0] key);
    logic [27:0] obs[$];
    logic [27:0] exp[$];
    int  wall = 0;
    int  writes = 0;
    int  n;
    logic done = 1'b0;
    logic aborted = 1'b0;
    mem_key = key;
    for (int k = 0; k < (odd ? 2 : 1); k++) exp.push_back(op_word(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0));
    for (int i = 0; i < 256; i++) begin
      exp.push_back(op_word(1'b1, 1'b1, 1'b1, 1'b0, {page, 8'(i)}, 8'h0));
      exp.push_back(op_word(1'b1, 1'b1, 1'b0, 1'b1, 16'h2004, 8'(i) ^ key));
    end
    ce = 1'b1; odd_cycle = odd; cpu_write = 1'b1; cpu_addr = 16'h4014; cpu_din = page;
    @(posedge clk); #1;
    cpu_write = 1'b0; cpu_addr = 16'h0000;
    while (!done && !aborted && wall < 4000) begin
      if (!pause_cpu && !dma_active && !dma_read && !dma_write) begin
        done = 1'b1;
      end else begin
        case (ce_mode)
          0:       ce = 1'b1;
          1:       ce = (wall % 3 == 2);
          default: ce = 1'($urandom_range(0, 1));
        endcase
        cpu_write = poke && ($urandom_range(0, 7) == 0);
        cpu_addr  = ($urandom_range(0, 1) == 1) ? 16'h4014 : 16'h4015;
        cpu_din   = page ^ 8'h5A;
        if (ce) begin
          obs.push_back(op_word(pause_cpu, dma_active, dma_read, dma_write, dma_addr, dma_dout));
          if (dma_write) writes++;
        end
        @(posedge clk); #1;
        wall++;
        cpu_write = 1'b0;
        if (abort_at > 0 && writes == abort_at) begin
          reset = 1'b1;
          ce = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          chk("abort_flags", 32'({pause_cpu, dma_active, dma_read, dma_write}), 32'h0);
          chk("abort_addr", 32'(dma_addr), 32'h0);
          chk("abort_dout", 32'(dma_dout), 32'h0);
          reset = 1'b0;
          aborted = 1'b1;
        end
      end
    end
    if (!aborted) begin
      chk("transfer_done", 32'(done), 32'h1);
      chk("duration", 32'(obs.size()), 32'(513 + int'(odd)));
    end
    n = (obs.size() < exp.size()) ? obs.size() : exp.size();
    for (int i = 0; i < n; i++) chk($sformatf("op%0d", i), 32'(obs[i]), 32'(exp[i]));
    if (aborted) begin
      last_byte = 8'h00;
    end else begin
      last_byte = 8'hFF ^ key;
      chk("dout_hold", 32'(dma_dout), 32'(last_byte));
      chk("idle_flags", 32'({pause_cpu, dma_active, dma_read, dma_write}), 32'h0);
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; odd_cycle = 1'b0; cpu_write = 1'b0;
    cpu_addr = 16'h0000; cpu_din = 8'h00; mem_key = 8'h00; last_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", 32'({pause_cpu, dma_active, dma_read, dma_write}), 32'h0);
    chk("reset_addr", 32'(dma_addr), 32'h0);
    chk("reset_dout", 32'(dma_dout), 32'h0);
    reset = 1'b0;
    idle_pokes(6);

    run_transfer(8'h02, 1'b0, 0, 1'b0, 0, 8'($urandom));
    run_transfer(8'h02, 1'b1, 0, 1'b0, 0, 8'($urandom));
    run_transfer(8'($urandom), 1'($urandom), 0, 1'b0, 0, 8'hA5);
    run_transfer(8'($urandom), 1'($urandom), 1, 1'b0, 0, 8'($urandom));
    run_transfer(8'($urandom), 1'($urandom), 2, 1'b0, 100, 8'($urandom));
    idle_pokes(3);
    run_transfer(8'($urandom), 1'b0, 0, 1'b0, 0, 8'($urandom));
    run_transfer(8'hFF, 1'($urandom), 2, 1'b1, 0, 8'($urandom));
    idle_pokes(4);
    for (int t = 0; t < 2; t++) begin
      run_transfer(8'($urandom), 1'($urandom), 2, 1'b1, 0, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
